mem_arbiter: RTL and testbench

//  Shares the single off-chip memory port between the I-cache and D-cache miss/write-back interfaces.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths and FSM encoding for the cache/memory arbiter
package mem_arbiter_pkg;

  localparam int BLK_ADDR_W = 28;
  localparam int BLK_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between I-cache and D-cache, one owner at a time
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = BLK_ADDR_W,
  parameter int DATA_W = BLK_DATA_W,
  parameter int RR_EN  = 0,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              rst_n,
  input  logic              ic_read,
  input  logic              ic_write,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [DATA_W-1:0] ic_wdata,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  ic_grants,
  output logic [CNT_W-1:0]  dc_grants
);

  arb_state_t state, next_state;
  logic       last_d;
  logic       grant_i, grant_d, done_i, done_d;
  logic       req_i, req_d;

  assign req_i = ic_read | ic_write;
  assign req_d = dc_read | dc_write;

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done_i     = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, D wins unless round-robin says D went last
        grant_d = req_d & (~req_i | (RR_EN == 0) | ~last_d);
        grant_i = req_i & ~grant_d;
        if (grant_d)      next_state = BUSY_D;
        else if (grant_i) next_state = BUSY_I;
      end
      BUSY_I: begin
        done_i = mem_ready;
        if (mem_ready) next_state = RELEASE;
      end
      BUSY_D: begin
        done_d = mem_ready;
        if (mem_ready) next_state = RELEASE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
      ic_ready  <= 1'b0;
      dc_ready  <= 1'b0;
      ic_grants <= '0;
      dc_grants <= '0;
    end else begin
      state    <= next_state;
      ic_ready <= done_i;
      dc_ready <= done_d;
      if (grant_i) begin
        last_d    <= 1'b0;
        mem_addr  <= ic_addr;
        mem_wdata <= ic_wdata;
        mem_write <= ic_write;
        mem_read  <= ic_read & ~ic_write;
      end
      if (grant_d) begin
        last_d    <= 1'b1;
        mem_addr  <= dc_addr;
        mem_wdata <= dc_wdata;
        mem_write <= dc_write;
        mem_read  <= dc_read & ~dc_write;
      end
      if (done_i | done_d) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (done_i) begin
        ic_rdata <= mem_rdata;
        if (ic_grants != '1) ic_grants <= ic_grants + CNT_W'(1);
      end
      if (done_d) begin
        dc_rdata <= mem_rdata;
        if (dc_grants != '1) dc_grants <= dc_grants + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - random cache/memory traffic against a transaction-level arbiter model
module tb_mem_arbiter;

  logic i_clk;
  logic rst_n;

  // index [k][s]: k=0 fixed-priority/2-bit counters, k=1 round-robin/16-bit; s=0 I, s=1 D
  logic         rd[2][2], wr[2][2], rdy[2][2];
  logic [27:0]  addr[2][2];
  logic [127:0] wdata[2][2], rdata[2][2];
  logic         mrd[2], mwr[2], mrdy[2];
  logic [27:0]  maddr[2];
  logic [127:0] mwdata[2], mrdata[2];
  logic [1:0]   fx_gi, fx_gd;
  logic [15:0]  rr_gi, rr_gd;

  mem_arbiter #(.RR_EN(0), .CNT_W(2)) u_fixed (
    .i_clk(i_clk), .rst_n(rst_n),
    .ic_read(rd[0][0]), .ic_write(wr[0][0]), .ic_addr(addr[0][0]), .ic_wdata(wdata[0][0]),
    .ic_rdata(rdata[0][0]), .ic_ready(rdy[0][0]),
    .dc_read(rd[0][1]), .dc_write(wr[0][1]), .dc_addr(addr[0][1]), .dc_wdata(wdata[0][1]),
    .dc_rdata(rdata[0][1]), .dc_ready(rdy[0][1]),
    .mem_read(mrd[0]), .mem_write(mwr[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
    .mem_rdata(mrdata[0]), .mem_ready(mrdy[0]),
    .ic_grants(fx_gi), .dc_grants(fx_gd)
  );

  mem_arbiter #(.RR_EN(1), .CNT_W(16)) u_rr (
    .i_clk(i_clk), .rst_n(rst_n),
    .ic_read(rd[1][0]), .ic_write(wr[1][0]), .ic_addr(addr[1][0]), .ic_wdata(wdata[1][0]),
    .ic_rdata(rdata[1][0]), .ic_ready(rdy[1][0]),
    .dc_read(rd[1][1]), .dc_write(wr[1][1]), .dc_addr(addr[1][1]), .dc_wdata(wdata[1][1]),
    .dc_rdata(rdata[1][1]), .dc_ready(rdy[1][1]),
    .mem_read(mrd[1]), .mem_write(mwr[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
    .mem_rdata(mrdata[1]), .mem_ready(mrdy[1]),
    .ic_grants(rr_gi), .dc_grants(rr_gd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: who owns memory, whether the dead cycle is pending, last winner
  int           own[2];
  bit           dead[2], last_d[2];
  bit           e_rdy[2][2];
  logic [127:0] e_rdata[2][2];
  int           e_cnt[2][2];
  bit           e_mrd[2], e_mwr[2];
  logic [27:0]  e_maddr[2];
  logic [127:0] e_mwdata[2];
  int           lat[2];
  bit           rst_done;

  function automatic int cmax(int k);
    return (k == 0) ? 3 : 65535;
  endfunction

  function automatic int cnt_obs(int k, int s);
    if (k == 0) return (s == 0) ? int'(fx_gi) : int'(fx_gd);
    return (s == 0) ? int'(rr_gi) : int'(rr_gd);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; dead[k] = 0; last_d[k] = 0;
      e_mrd[k] = 0; e_mwr[k] = 0; e_maddr[k] = '0; e_mwdata[k] = '0;
      for (int s = 0; s < 2; s++) begin
        e_rdy[k][s] = 0; e_rdata[k][s] = '0; e_cnt[k][s] = 0;
      end
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      mrdy[k] = 0; mrdata[k] = '0; lat[k] = -1;
      for (int s = 0; s < 2; s++) begin
        rd[k][s] = 0; wr[k][s] = 0; addr[k][s] = '0; wdata[k][s] = '0;
      end
    end
  endtask

  task automatic compare_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        check($sformatf("%s_u%0d_s%0d_ready", ph, k, s), 128'(rdy[k][s]), 128'(e_rdy[k][s]));
        check($sformatf("%s_u%0d_s%0d_rdata", ph, k, s), rdata[k][s], e_rdata[k][s]);
        check($sformatf("%s_u%0d_s%0d_grants", ph, k, s), 128'(cnt_obs(k, s)), 128'(e_cnt[k][s]));
      end
      check($sformatf("%s_u%0d_mem_read", ph, k), 128'(mrd[k]), 128'(e_mrd[k]));
      check($sformatf("%s_u%0d_mem_write", ph, k), 128'(mwr[k]), 128'(e_mwr[k]));
      check($sformatf("%s_u%0d_mem_addr", ph, k), 128'(maddr[k]), 128'(e_maddr[k]));
      check($sformatf("%s_u%0d_mem_wdata", ph, k), mwdata[k], e_mwdata[k]);
      check($sformatf("%s_u%0d_ready_excl", ph, k), 128'(rdy[k][0] & rdy[k][1]), 128'(0));
      check($sformatf("%s_u%0d_strobe_excl", ph, k), 128'(mrd[k] & mwr[k]), 128'(0));
    end
  endtask

  // predicts what the next clock edge does, given the inputs now applied
  task automatic predict();
    for (int k = 0; k < 2; k++) begin
      e_rdy[k][0] = 0;
      e_rdy[k][1] = 0;
      if (own[k] >= 0) begin
        if (mrdy[k]) begin
          e_rdata[k][own[k]] = mrdata[k];
          e_rdy[k][own[k]]   = 1;
          if (e_cnt[k][own[k]] < cmax(k)) e_cnt[k][own[k]]++;
          e_mrd[k] = 0; e_mwr[k] = 0;
          own[k] = -1; dead[k] = 1;
        end
      end else if (dead[k]) begin
        dead[k] = 0;
      end else begin
        bit req0, req1;
        int pick;
        req0 = rd[k][0] | wr[k][0];
        req1 = rd[k][1] | wr[k][1];
        if (req0 || req1) begin
          if (req0 && req1) pick = (k == 1) ? (last_d[k] ? 0 : 1) : 1;
          else              pick = req1 ? 1 : 0;
          own[k]      = pick;
          last_d[k]   = (pick == 1);
          e_maddr[k]  = addr[k][pick];
          e_mwdata[k] = wdata[k][pick];
          e_mwr[k]    = wr[k][pick];
          e_mrd[k]    = rd[k][pick] & ~wr[k][pick];
        end
      end
    end
  endtask

  task automatic drive_agents();
    for (int k = 0; k < 2; k++) begin
      if (mrdy[k]) begin
        mrdy[k] = 0;
      end else if (mrd[k] | mwr[k]) begin
        if (lat[k] < 0) lat[k] = $urandom_range(0, 6);
        if (lat[k] == 0) begin
          mrdy[k] = 1; mrdata[k] = rand128(); lat[k] = -1;
        end else begin
          lat[k]--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mrdy[k] = 1; mrdata[k] = rand128();
      end
      for (int s = 0; s < 2; s++) begin
        if (rdy[k][s]) begin
          rd[k][s] = 0; wr[k][s] = 0;
        end else if (!rd[k][s] && !wr[k][s] && $urandom_range(0, 2) == 0) begin
          int op;
          op = $urandom_range(0, 7);
          rd[k][s]    = (op < 5) || (op == 7);
          wr[k][s]    = (op >= 5);
          addr[k][s]  = 28'($urandom);
          wdata[k][s] = rand128();
        end
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rst_done = 0;
    clear_inputs();
    model_reset();
    #1;
    compare_all("reset");
    repeat (2) @(negedge i_clk);
    rst_n = 1'b1;
    predict();
    for (int it = 0; it < 1500; it++) begin
      @(posedge i_clk);
      #1;
      compare_all("run");
      if (!rst_done && ((it >= 300 && own[1] == 1) || it == 700)) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        clear_inputs();
        compare_all("midrst");
        rst_done = 1;
        repeat (2) @(negedge i_clk);
        rst_n = 1'b1;
        predict();
      end else begin
        drive_agents();
        predict();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
